// File: rtl/majority_vector_driver.sv
// rtl/majority_vector_driver.sv - exhaustive stimulus source and checker for an N-input majority DUT
// Steps every input vector, holds it for a settle window, then scores dut_y against a popcount majority.
module majority_vector_driver #(
    parameter int N_IN       = 3,
    parameter int SETTLE_CYC = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] vec_out,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] fail_vec,
    output logic            fail_valid
);
    localparam int         PCW         = $clog2(N_IN + 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [N_IN-1:0] fvec_q, fvec_d;
    logic [N_IN:0]   err_q, err_d;
    logic            fvalid_q, fvalid_d;
    logic            pass_q, pass_d;
    logic [PCW-1:0]  ones;
    logic            expected;

    always_comb begin
        ones = '0;
        for (int i = 0; i < N_IN; i++) begin
            ones = ones + PCW'(vec_q[i]);
        end
        expected = (ones > PCW'(N_IN / 2));
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        vec_d    = vec_q;
        err_d    = err_q;
        fvec_d   = fvec_q;
        fvalid_d = fvalid_q;
        pass_d   = pass_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_SETTLE;
                    cnt_d    = '0;
                    vec_d    = '0;
                    err_d    = '0;
                    fvec_d   = '0;
                    fvalid_d = 1'b0;
                    pass_d   = 1'b0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_CHECK: begin
                if (dut_y != expected) begin
                    err_d = err_q + (N_IN + 1)'(1);
                    if (!fvalid_q) begin
                        fvec_d   = vec_q;
                        fvalid_d = 1'b1;
                    end
                end
                // pass must include the final vector's comparison, so it reads err_d
                if (&vec_q) begin
                    state_d = S_DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                    vec_d   = vec_q + N_IN'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            vec_q    <= '0;
            err_q    <= '0;
            fvec_q   <= '0;
            fvalid_q <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vec_q    <= vec_d;
            err_q    <= err_d;
            fvec_q   <= fvec_d;
            fvalid_q <= fvalid_d;
            pass_q   <= pass_d;
        end
    end

    assign vec_out    = vec_q;
    assign busy       = (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign done       = (state_q == S_DONE);
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_vec   = fvec_q;
    assign fail_valid = fvalid_q;

endmodule

// File: tb/tb_majority_vector_driver.sv
// tb/tb_majority_vector_driver.sv - randomized bench for majority_vector_driver with a run-level reference model
// DUT behaviour modes: 0 ideal, 1 stuck-0, 2 stuck-1, 3 inverted, 4 random per cycle.
module tb_majority_vector_driver;
    localparam int N  = 3;
    localparam int S  = 2;
    localparam int P  = S + 1;
    localparam int NV = 1 << N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] vec_out;
    logic         dut_y;
    logic         busy, done, pass, fail_valid;
    logic [N:0]   err_count;
    logic [N-1:0] fail_vec;

    int   mode = 0;
    logic rnd_bit = 1'b0;
    bit   cmp_en = 1'b0;
    int   n_pass = 0;
    int   n_tot = 0;

    int m_t = 0, m_err = 0, m_fvec = 0, m_vec = 0;
    bit m_run = 0, m_done = 0, m_pass = 0, m_fvalid = 0;

    majority_vector_driver #(.N_IN(N), .SETTLE_CYC(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_out(vec_out), .dut_y(dut_y),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_vec(fail_vec), .fail_valid(fail_valid)
    );

    always #5 clk = ~clk;

    function automatic logic maj(input logic [N-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < N; i++) c += int'(v[i]);
        return c > N / 2;
    endfunction

    assign dut_y = (mode == 0) ? maj(vec_out) :
                   (mode == 1) ? 1'b0 :
                   (mode == 2) ? 1'b1 :
                   (mode == 3) ? ~maj(vec_out) : rnd_bit;

    always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));

    task automatic check(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Run-level model: a run is NV vectors of P cycles each; vector v is judged on the last cycle of its slot.
    initial forever begin
        logic [N-1:0] vv;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_run = 0; m_t = 0; m_done = 0; m_pass = 0; m_fvalid = 0; m_err = 0; m_fvec = 0; m_vec = 0;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_t = 0; m_vec = 0; m_err = 0; m_fvalid = 0; m_fvec = 0; m_pass = 0; m_done = 0;
            end
        end else begin
            if (m_t % P == P - 1) begin
                vv = N'(m_t / P);
                if (dut_y !== ($countones(vv) > N / 2)) begin
                    m_err++;
                    if (!m_fvalid) begin
                        m_fvalid = 1;
                        m_fvec = int'(vv);
                    end
                end
            end
            m_t++;
            if (m_t == NV * P) begin
                m_run = 0; m_done = 1; m_pass = (m_err == 0); m_vec = NV - 1;
            end else begin
                m_vec = m_t / P;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("vec_out", int'(vec_out), m_vec);
            check("busy", int'(busy), int'(m_run));
            check("done", int'(done), int'(m_done));
            check("pass", int'(pass), int'(m_pass));
            check("err_count", int'(err_count), m_err);
            check("fail_vec", int'(fail_vec), m_fvec);
            check("fail_valid", int'(fail_valid), int'(m_fvalid));
        end
    end

    task automatic run(input int md, input bit noisy);
        int cyc;
        mode = md;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            if (noisy) start = ($urandom_range(0, 3) == 0);
            cyc++;
        end
        start = 1'b0;
        check("run_finished", int'(cyc < 200), 1);
        check("done_latency", cyc - 1, 24);
    endtask

    task automatic expect_result(input string tag, input int e, input int fv, input int fvl, input int ps);
        check({tag, "_err"}, int'(err_count), e);
        check({tag, "_fail_vec"}, int'(fail_vec), fv);
        check({tag, "_fail_valid"}, int'(fail_valid), fvl);
        check({tag, "_pass"}, int'(pass), ps);
    endtask

    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        check("rst_vec", int'(vec_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err_count), 0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        run(0, 0); expect_result("ideal", 0, 0, 0, 1);
        check("model_ideal_err", m_err, 0);
        run(1, 0); expect_result("stuck0", 4, 3, 1, 0);
        check("model_stuck0_err", m_err, 4);
        run(2, 0); expect_result("stuck1", 4, 0, 1, 0);
        run(3, 0); expect_result("invert", 8, 0, 1, 0);
        check("model_invert_err", m_err, 8);

        // start held high: one completion, then restart on the following edge
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) cnt++;
            if (i == 25) begin
                check("hold_restart_busy", int'(busy), 1);
                check("hold_restart_vec", int'(vec_out), 0);
                check("hold_restart_err", int'(err_count), 0);
            end
        end
        start = 1'b0;
        check("hold_done_cycles", cnt, 1);
        cnt = 0;
        while (!done && cnt < 100) begin @(negedge clk); cnt++; end
        check("hold_second_run_done", int'(done), 1);

        // asynchronous reset mid-run while vector 5 is driven
        mode = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cnt = 0;
        while (vec_out != 3'd5 && cnt < 100) begin @(negedge clk); cnt++; end
        check("reached_vec5", int'(vec_out), 5);
        #2 rst_n = 1'b0;
        #1;
        check("async_vec", int'(vec_out), 0);
        check("async_busy", int'(busy), 0);
        check("async_done", int'(done), 0);
        check("async_err", int'(err_count), 0);
        check("async_fail_valid", int'(fail_valid), 0);
        #1 rst_n = 1'b1;
        run(0, 0); expect_result("post_rst", 0, 0, 0, 1);

        // randomized DUT behaviour with stray start pulses during runs
        for (int r = 0; r < 8; r++) begin
            run(int'($urandom_range(0, 4)), 1);
        end

        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1);
    end

endmodule
